// File: rtl/soc_bus_pkg.sv
// Shared definitions for the SoC RAM bus: widths, arbiter state encoding
// and small helpers used by every bus master / arbiter block.
package soc_bus_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int WMASK_W      = 4;

    // Arbiter sequencing states; encoding shared with other bus blocks.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_t;

    // A master is requesting when it strobes a read or presents any write byte.
    function automatic logic bus_request(input logic rstrb, input logic [WMASK_W-1:0] wmask);
        return rstrb | (|wmask);
    endfunction

    // Any write byte makes the access a write, even if rstrb is also high.
    function automatic logic bus_is_write(input logic [WMASK_W-1:0] wmask);
        return |wmask;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker. On a tie the master that was not
// served last wins; a lone requester always wins.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic grant_valid,
    output logic grant_idx
);

    // Pick a winner from the current requests and the last-served index.
    always_comb begin
        grant_valid = req0 | req1;
        grant_idx   = 1'b0;
        if (req0 && req1) begin
            grant_idx = ~last;
        end else if (req1) begin
            grant_idx = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of the single registered-read SoC RAM port.
// One transaction at a time: IDLE -> ACCESS (RAM samples) -> RESP (ready).
// A waiting second master is granted straight out of RESP with no bubble.
module mem_arbiter
    import soc_bus_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [XLEN-1:0]    m0_addr,
    input  logic               m0_rstrb,
    input  logic [XLEN-1:0]    m0_wdata,
    input  logic [WMASK_W-1:0] m0_wmask,
    output logic [XLEN-1:0]    m0_rdata,
    output logic               m0_ready,
    input  logic [XLEN-1:0]    m1_addr,
    input  logic               m1_rstrb,
    input  logic [XLEN-1:0]    m1_wdata,
    input  logic [WMASK_W-1:0] m1_wmask,
    output logic [XLEN-1:0]    m1_rdata,
    output logic               m1_ready,
    output logic [XLEN-1:0]    mem_addr,
    output logic               mem_rstrb,
    output logic [XLEN-1:0]    mem_wdata,
    output logic [WMASK_W-1:0] mem_wmask,
    input  logic [XLEN-1:0]    mem_rdata,
    output logic               busy,
    output logic               owner
);

    arb_state_t state_reg, state_next;
    logic       owner_reg, owner_next;
    logic       last_reg, last_next;

    // Per-master views of the bus so selection is a plain index by owner.
    logic [XLEN-1:0]    m_addr  [2];
    logic [XLEN-1:0]    m_wdata [2];
    logic [WMASK_W-1:0] m_wmask [2];
    logic [1:0]         m_rstrb;
    logic [1:0]         req;
    logic [1:0]         ready_vec;

    logic grant_valid;
    logic grant_idx;
    logic other_idx;
    logic sel_write;

    assign m_addr[0]  = m0_addr;
    assign m_addr[1]  = m1_addr;
    assign m_wdata[0] = m0_wdata;
    assign m_wdata[1] = m1_wdata;
    assign m_wmask[0] = m0_wmask;
    assign m_wmask[1] = m1_wmask;
    assign m_rstrb    = {m1_rstrb, m0_rstrb};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_master
            assign req[gi]       = bus_request(m_rstrb[gi], m_wmask[gi]);
            assign ready_vec[gi] = (state_reg == ST_RESP) && (owner_reg == 1'(gi));
        end
    endgenerate

    // Tie-break only matters in IDLE; RESP always hands over to the other master.
    rr_pick2 u_pick (
        .req0        (req[0]),
        .req1        (req[1]),
        .last        (last_reg),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign other_idx = ~owner_reg;
    assign sel_write = bus_is_write(m_wmask[owner_reg]);

    // State, owner and last-served registers; last starts at 1 so master 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            owner_reg <= 1'b0;
            last_reg  <= 1'b1;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            last_reg  <= last_next;
        end
    end

    // Next-state logic: grant from IDLE, one ACCESS cycle, one RESP cycle.
    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        last_next  = last_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (grant_valid) begin
                    owner_next = grant_idx;
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                last_next  = owner_reg;
                state_next = ST_RESP;
            end
            ST_RESP: begin
                // The owner's request is still its completing one, so only the other counts.
                if (req[other_idx]) begin
                    owner_next = other_idx;
                    state_next = ST_ACCESS;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // RAM drive: address/data always follow the owner, strobes only live in ACCESS.
    always_comb begin
        mem_addr  = m_addr[owner_reg];
        mem_wdata = m_wdata[owner_reg];
        mem_wmask = '0;
        mem_rstrb = 1'b0;
        if (state_reg == ST_ACCESS) begin
            mem_wmask = m_wmask[owner_reg];
            mem_rstrb = m_rstrb[owner_reg] & ~sel_write;
        end
    end

    assign m0_ready = ready_vec[0];
    assign m1_ready = ready_vec[1];
    assign m0_rdata = mem_rdata;
    assign m1_rdata = mem_rdata;
    assign busy     = (state_reg != ST_IDLE);
    assign owner    = owner_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// traffic from both masters, checked against a transaction-level model
// (single server, two-cycle service, round-robin on ties, shadow memory).
module tb_mem_arbiter;
    import soc_bus_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [XLEN-1:0] dr_addr  [2];
    logic [XLEN-1:0] dr_wdata [2];
    logic [3:0]      dr_wmask [2];
    logic            dr_rstrb [2];

    logic [XLEN-1:0] m0_rdata, m1_rdata;
    logic            m0_ready, m1_ready;
    logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;
    logic            mem_rstrb;
    logic [3:0]      mem_wmask;
    logic            busy, owner;

    always #5 clk = ~clk;

    mem_arbiter #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_addr   (dr_addr[0]),
        .m0_rstrb  (dr_rstrb[0]),
        .m0_wdata  (dr_wdata[0]),
        .m0_wmask  (dr_wmask[0]),
        .m0_rdata  (m0_rdata),
        .m0_ready  (m0_ready),
        .m1_addr   (dr_addr[1]),
        .m1_rstrb  (dr_rstrb[1]),
        .m1_wdata  (dr_wdata[1]),
        .m1_wmask  (dr_wmask[1]),
        .m1_rdata  (m1_rdata),
        .m1_ready  (m1_ready),
        .mem_addr  (mem_addr),
        .mem_rstrb (mem_rstrb),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .owner     (owner)
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'hDEADBEEF;
        if (i == 8) return 32'hAABBCCDD;
        return 32'h5A000000 + 32'(i * 32'h00010203);
    endfunction

    // RAM model: registered read the cycle after mem_rstrb, byte-masked writes.
    logic [31:0] ram [64];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
        end else begin
            if (mem_rstrb) mem_rdata <= ram[mem_addr[7:2]];
            for (int b = 0; b < 4; b++)
                if (mem_wmask[b]) ram[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    // Reference model state
    logic [31:0] shadow [64];
    int  cyc = 0;
    int  acc_cyc = -1, rsp_cyc = -1, cur = 0;
    int  model_last = 1, model_owner = 0;
    bit  act [2], drop_q [2], done [2];
    int  done_cyc [2], iss_cyc [2];
    logic [31:0] got_rdata [2];
    int  grant_log [$];
    int  n_vec = 0, n_err = 0;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        acc_cyc = -1; rsp_cyc = -1; cur = 0;
        model_last = 1; model_owner = 0;
        for (int m = 0; m < 2; m++) begin
            act[m] = 0; drop_q[m] = 0;
            dr_rstrb[m] = 1'b0; dr_wmask[m] = 4'h0;
        end
        for (int i = 0; i < 64; i++) shadow[i] = init_word(i);
    endtask

    task automatic issue(input int m, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] wm, input logic rs);
        dr_addr[m] = a; dr_wdata[m] = wd; dr_wmask[m] = wm; dr_rstrb[m] = rs;
        act[m] = 1; done[m] = 0; iss_cyc[m] = cyc;
        $display("cycle %0d: m%0d issues %s addr=%h wdata=%h wmask=%b", cyc, m,
                 (wm != 0) ? "write" : "read", a, wd, wm);
    endtask

    // Compare every observable output for the cycle just sampled.
    task automatic check_cycle();
        logic [31:0] rd, merged;
        int idx;
        chk1("m0_ready", m0_ready, (cyc == rsp_cyc) && (cur == 0));
        chk1("m1_ready", m1_ready, (cyc == rsp_cyc) && (cur == 1));
        chk1("busy", busy, (cyc == acc_cyc) || (cyc == rsp_cyc));
        chk1("owner", owner, model_owner[0]);
        if (cyc == acc_cyc) begin
            chk32("mem_addr", mem_addr, dr_addr[cur]);
            chk32("mem_wmask", {28'h0, mem_wmask}, {28'h0, dr_wmask[cur]});
            chk1("mem_rstrb", mem_rstrb, dr_rstrb[cur] && (dr_wmask[cur] == 4'h0));
            if (dr_wmask[cur] != 4'h0) chk32("mem_wdata", mem_wdata, dr_wdata[cur]);
        end else begin
            chk1("idle_rstrb", mem_rstrb, 1'b0);
            chk32("idle_wmask", {28'h0, mem_wmask}, 32'h0);
        end
        if (cyc == rsp_cyc) begin
            idx = int'(dr_addr[cur][7:2]);
            rd  = (cur == 1) ? m1_rdata : m0_rdata;
            if (dr_wmask[cur] == 4'h0) begin
                chk32("rdata", rd, shadow[idx]);
                got_rdata[cur] = rd;
            end else begin
                merged = shadow[idx];
                for (int b = 0; b < 4; b++)
                    if (dr_wmask[cur][b]) merged[8*b +: 8] = dr_wdata[cur][8*b +: 8];
                shadow[idx] = merged;
            end
            done[cur] = 1; done_cyc[cur] = cyc; drop_q[cur] = 1;
            grant_log.push_back(cur);
            $display("cycle %0d: m%0d ready rdata=%h", cyc, cur, rd);
        end
    endtask

    // One clock: model decision for the coming edge, edge, drops, sample.
    task automatic tick();
        bit c0, c1;
        int g;
        if (reset) begin
            model_reset();
        end else if (cyc != acc_cyc) begin
            c0 = act[0] && !((cyc == rsp_cyc) && (cur == 0));
            c1 = act[1] && !((cyc == rsp_cyc) && (cur == 1));
            g = -1;
            if (c0 && c1) g = 1 - model_last;
            else if (c0) g = 0;
            else if (c1) g = 1;
            if (g >= 0) begin
                acc_cyc = cyc + 1; rsp_cyc = cyc + 2; cur = g;
                model_last = g; model_owner = g;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        for (int m = 0; m < 2; m++) begin
            if (drop_q[m]) begin
                dr_rstrb[m] = 1'b0; dr_wmask[m] = 4'h0; act[m] = 0; drop_q[m] = 0;
            end
        end
        @(negedge clk);
        check_cycle();
    endtask

    task automatic wait_done(input int m, input int budget);
        int n = 0;
        while (!done[m] && n < budget) begin
            tick();
            n++;
        end
        n_vec++;
        assert (done[m]) else begin
            n_err++;
            $error("FAIL timeout_m%0d: observed no ready after %0d cycles expected ready", m, budget);
        end
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            dr_addr[m] = '0; dr_wdata[m] = '0; dr_wmask[m] = 4'h0; dr_rstrb[m] = 1'b0;
        end

        // Reset, then a single m0 read of 0x10
        reset = 1'b1; tick(); tick();
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_owner", owner, 1'b0);
        reset = 1'b0; tick();
        issue(0, 32'h10, 32'h0, 4'h0, 1'b1);
        wait_done(0, 10);
        chk32("t1_rdata", got_rdata[0], 32'hDEADBEEF);
        chk32("t1_latency", 32'(done_cyc[0] - iss_cyc[0]), 32'd2);
        tick();

        // m1 partial write, then m0 reads it back
        issue(1, 32'h20, 32'h12345678, 4'b0011, 1'b0);
        wait_done(1, 10);
        chk32("t2_latency", 32'(done_cyc[1] - iss_cyc[1]), 32'd2);
        tick();
        issue(0, 32'h20, 32'h0, 4'h0, 1'b1);
        wait_done(0, 10);
        chk32("t2_readback", got_rdata[0], 32'hAABB5678);
        tick();

        // rstrb together with full wmask is a write
        issue(0, 32'h30, 32'hCAFEF00D, 4'b1111, 1'b1);
        wait_done(0, 10);
        chk32("t4_latency", 32'(done_cyc[0] - iss_cyc[0]), 32'd2);
        tick();
        issue(1, 32'h30, 32'h0, 4'h0, 1'b1);
        wait_done(1, 10);
        chk32("t4_readback", got_rdata[1], 32'hCAFEF00D);
        tick();

        // Reset during ACCESS of an m0 read
        issue(0, 32'h10, 32'h0, 4'h0, 1'b1);
        tick();
        chk1("t5_access_rstrb", mem_rstrb, 1'b1);
        reset = 1'b1; tick();
        reset = 1'b0;
        chk1("t5_busy_after_rst", busy, 1'b0);
        tick(); tick();
        chk1("t5_no_ready", done[0], 1'b0);
        issue(0, 32'h10, 32'h0, 4'h0, 1'b1);
        wait_done(0, 10);
        chk32("t5_reissue_rdata", got_rdata[0], 32'hDEADBEEF);
        tick();

        // m1 alone, three back-to-back requests
        for (int k = 0; k < 3; k++) begin
            issue(1, 32'(k * 4), 32'h0, 4'h0, 1'b1);
            wait_done(1, 10);
            chk32("t6_latency", 32'(done_cyc[1] - iss_cyc[1]), 32'd2);
            chk1("t6_owner", owner, 1'b1);
            tick();
        end

        // Both masters continuously requesting from reset
        reset = 1'b1; tick();
        reset = 1'b0; tick();
        grant_log.delete();
        issue(0, 32'h04, 32'h0, 4'h0, 1'b1);
        issue(1, 32'h08, 32'h0, 4'h0, 1'b1);
        for (int n = 0; n < 12; n++) begin
            tick();
            chk1("t3_busy", busy, 1'b1);
            for (int m = 0; m < 2; m++)
                if (!act[m]) issue(m, 32'(m * 4 + 4), 32'h0, 4'h0, 1'b1);
        end
        n_vec++;
        assert (grant_log.size() >= 4) else begin
            n_err++;
            $error("FAIL t3_count: observed %0d grants expected >= 4", grant_log.size());
        end
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            chk32("t3_order", 32'(grant_log[i]), 32'(i % 2));

        // Random traffic from both masters
        reset = 1'b1; tick();
        reset = 1'b0; tick();
        for (int n = 0; n < 300; n++) begin
            for (int m = 0; m < 2; m++) begin
                if (!act[m] && ($urandom_range(0, 1) == 1)) begin
                    case ($urandom_range(0, 2))
                        0: issue(m, 32'($urandom_range(0, 63) * 4), $urandom, 4'h0, 1'b1);
                        1: issue(m, 32'($urandom_range(0, 63) * 4), $urandom,
                                 4'($urandom_range(1, 15)), 1'b0);
                        default: issue(m, 32'($urandom_range(0, 63) * 4), $urandom,
                                       4'($urandom_range(1, 15)), 1'b1);
                    endcase
                end
            end
            tick();
        end
        for (int n = 0; n < 6; n++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master arbiter for the single SoC RAM port (addr/rdata/rstrb/wdata/wmask bus).
- Master 0 is the processor. Master 1 is a second bus master (program loader / DMA).
- Sits between the masters and the memory block. Grants one transaction at a time with round-robin fairness.
- Sequences the RAM's one-cycle registered-read timing and returns a per-master ready strobe.

Parameters:
- XLEN, 32, data and address width of every bus signal.

Ports:
- clk  input  1  system clock (post-divider clock)
- reset  input  1  synchronous, active-high reset
- m0_addr  input  XLEN  master 0 byte address
- m0_rstrb  input  1  master 0 read request, level, held until m0_ready
- m0_wdata  input  XLEN  master 0 write data
- m0_wmask  input  4  master 0 byte write mask; nonzero = write request, held until m0_ready
- m0_rdata  output  XLEN  master 0 read data; valid when m0_ready=1 for a read
- m0_ready  output  1  one-cycle completion strobe to master 0
- m1_addr, m1_rstrb, m1_wdata, m1_wmask, m1_rdata, m1_ready  same as m0_* for master 1
- mem_addr  output  XLEN  RAM address
- mem_rstrb  output  1  RAM read strobe
- mem_wdata  output  XLEN  RAM write data
- mem_wmask  output  4  RAM byte write mask
- mem_rdata  input  XLEN  RAM read data, registered, valid the cycle after mem_rstrb
- busy  output  1  arbiter in ACCESS or RESP
- owner  output  1  index of the currently or last granted master

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Request definition: reqN = mN_rstrb | (|mN_wmask).
  - If both rstrb and wmask are nonzero, the request is a write only; mem_rstrb is 0 for that access.
- Master contract: addr, wdata, wmask and rstrb stay stable from request until the mN_ready cycle inclusive. The master drops or changes its request the cycle after ready.
- States: IDLE, ACCESS, RESP (shared encoding).
- IDLE:
  - No request: stay in IDLE.
  - One request: owner <= that master; go to ACCESS.
  - Both requesting: owner <= !last; go to ACCESS.
- ACCESS (exactly 1 cycle):
  - mem_addr/mem_wdata/mem_wmask/mem_rstrb are driven combinationally from the owner's inputs. RAM samples them at the end of this cycle.
  - last <= owner; go to RESP.
- RESP (exactly 1 cycle):
  - mN_ready=1 for N=owner only.
  - For a read, mem_rdata is valid and passes straight through to mN_rdata.
  - If the other master is requesting: owner <= other; go directly to ACCESS (back-to-back, no idle bubble).
  - Otherwise: go to IDLE.
  - The owner's own request is ignored in RESP, because it is still asserted from the completing transaction.
- Latency: request seen in IDLE -> ready 2 cycles later (IDLE edge -> ACCESS -> RESP). Throughput with both masters busy is one transaction per 2 cycles, alternating 0,1,0,1.
- Outside ACCESS:
  - mem_rstrb=0 and mem_wmask=0, unconditionally.
  - mem_addr and mem_wdata follow the owner's inputs, which is harmless.
- m0_rdata = m1_rdata = mem_rdata, combinational. Data is meaningful only in the matching ready cycle.
- busy = (state != IDLE).
- Reset values: state=IDLE, owner=0, last=1 (master 0 wins the first tie), m0_ready=m1_ready=0, mem_rstrb=0, mem_wmask=0, busy=0.
- Reset mid-transaction: return to IDLE at once, with no ready pulse.
  - A write already sampled by RAM in ACCESS is not undone.
  - Masters must reissue after reset.
- Single master only (other idle): that master is re-granted on every request. Round-robin affects ties only.

Decomposition:
- Shared package (or include) soc_bus_pkg:
  - State encoding localparams: ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_RESP=2'd2.
  - Bus widths: WMASK_W=4, XLEN default.
- One natural sub-module: rr_pick2. This is a combinational 2-way round-robin picker, (req0, req1, last) -> (grant_valid, grant_idx), reusable for future bus masters.

Test Plan:
- Reset then m0 read @0x10 (RAM[4]=0xDEADBEEF) -> mem_rstrb=1 with mem_addr=0x10 exactly one cycle; m0_ready and m0_rdata=0xDEADBEEF 2 cycles after request; m1_ready stays 0.
- m1 write addr 0x20, wdata 0x12345678, wmask 4'b0011 -> mem_wmask=4'b0011 for one cycle; m1_ready next cycle; a subsequent m0 read @0x20 returns 0x????5678 with upper bytes unchanged.
- m0 and m1 both request continuously from reset -> grant order 0,1,0,1; a ready every 2 cycles; busy stays 1; no idle cycle between grants.
- Request with rstrb=1 and wmask=4'b1111 -> treated as a write; mem_rstrb=0 during ACCESS; ready after 2 cycles.
- Assert reset during ACCESS of an m0 read -> next cycle state IDLE, m0_ready never pulses, mem_rstrb=0; after reset release, a reissued read completes normally.
- m1 requests alone 3 times back-to-back (drops each request for 1 cycle after ready) -> three grants to m1, each with 2-cycle latency; owner=1 throughout.
